// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a 4:1 mux select through channels 0..3 and captures a snapshot
// Each select is held DWELL cycles; only the last cycle of each dwell is sampled.
module mux_scan_sequencer #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_out,
  input  logic       snap_ready,
  output logic [1:0] ss,
  output logic [3:0] snap,
  output logic       snap_valid,
  output logic       busy,
  output logic       overrun
);

  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic [2:0]    cap;
  logic          dwell_done;
  logic          scan_done;

  always_comb begin
    dwell_done = (state == SCAN) && (cnt == LAST);
    scan_done  = dwell_done && (ss == 2'd3);
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SCAN;
      SCAN:    if (scan_done) next_state = OUT;
      OUT:     if (snap_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss         <= 2'd0;
      cnt        <= '0;
      cap        <= 3'd0;
      snap       <= 4'd0;
      snap_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= start && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            ss  <= 2'd0;
            cnt <= '0;
            cap <= 3'd0;
          end
        end
        SCAN: begin
          if (dwell_done) begin
            cnt <= '0;
            if (ss == 2'd3) begin
              // Channel 3 goes straight into the snapshot, bypassing cap.
              snap       <= {mux_out, cap};
              snap_valid <= 1'b1;
              ss         <= 2'd0;
            end else begin
              cap <= cap | (3'(mux_out) << ss);
              ss  <= ss + 2'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        OUT: begin
          if (snap_ready) snap_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - scoreboard bench for mux_scan_sequencer at DWELL 2, 3 and 1
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [3];
  logic       snap_ready [3];
  logic       ovr_en [3];
  logic       ovr_val [3];
  logic [3:0] data [3];
  logic       mux_out [3];
  logic [1:0] ss [3];
  logic [3:0] snap [3];
  logic       snap_valid [3];
  logic       busy [3];
  logic       overrun [3];

  logic [3:0] exp_q [3][$];
  int         ov_cnt [3];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: DWELL=2, instance 1: DWELL=3, instance 2: DWELL=1.
  for (genvar g = 0; g < 3; g++) begin : gen
    localparam int DW = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
    assign mux_out[g] = ovr_en[g] ? ovr_val[g] : data[g][ss[g]];
    mux_scan_sequencer #(.DWELL(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start[g]),
      .mux_out    (mux_out[g]),
      .snap_ready (snap_ready[g]),
      .ss         (ss[g]),
      .snap       (snap[g]),
      .snap_valid (snap_valid[g]),
      .busy       (busy[g]),
      .overrun    (overrun[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    for (int g = 0; g < 3; g++) begin
      if (overrun[g]) ov_cnt[g]++;
      if (rst_n && snap_valid[g] && snap_ready[g]) begin
        if (exp_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_snap inst %0d actual %b expected none", g, snap[g]);
        end else begin
          e = exp_q[g].pop_front();
          chk($sformatf("snap_inst%0d", g), int'(snap[g]), int'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int g, output int t);
    int n;
    n = 0;
    @(negedge clk);
    while (!snap_valid[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!snap_valid[g]) begin
      checks++;
      errors++;
      $display("FAIL timeout_valid inst %0d actual 0 expected 1", g);
    end
    t = cyc;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy[g]) begin
      checks++;
      errors++;
      $display("FAIL timeout_idle inst %0d actual 1 expected 0", g);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, n, base;
    logic [11:0] pat;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0; snap_ready[g] = 1'b1; ovr_en[g] = 1'b0; ovr_val[g] = 1'b0; data[g] = 4'd0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("reset_outs_inst%0d", g), int'({ss[g], snap[g], snap_valid[g], busy[g], overrun[g]}), 0);
    tick();
    rst_n = 1'b1;

    // Basic scan, DWELL=2, data 1010.
    data[0] = 4'b1010;
    exp_q[0].push_back(4'b1010);
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("basic_ss_cycle%0d", i), int'(ss[0]), i / 2);
    end
    @(negedge clk);
    chk("basic_valid_after_e8", int'({snap_valid[0], busy[0]}), 3);
    @(negedge clk);
    chk("basic_busy_fall_after_e9", int'({snap_valid[0], busy[0], ss[0]}), 0);

    // Backpressure: snap_ready low for several cycles.
    snap_ready[0] = 1'b0;
    exp_q[0].push_back(4'b1010);
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_valid(0, t0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", int'({snap_valid[0], snap[0], ss[0]}), 9'b1_1010_00);
      @(negedge clk);
    end
    tick();
    snap_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_released_idle", int'({snap_valid[0], busy[0]}), 0);
    chk("bp_snap_kept", int'(snap[0]), 4'b1010);

    // Overrun: ignored starts mid-scan and in OUT.
    base = ov_cnt[0];
    data[0] = 4'b0101;
    snap_ready[0] = 1'b0;
    exp_q[0].push_back(4'b0101);
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_valid(0, t0);
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    snap_ready[0] = 1'b1;
    @(negedge clk);
    tick();
    tick();
    chk("overrun_count", ov_cnt[0] - base, 2);
    chk("overrun_back_idle", int'(busy[0]), 0);

    // Settle filtering, DWELL=3: only the last cycle of each dwell counts.
    pat = 12'b1000_1111_0101;
    exp_q[1].push_back(4'b1011);
    tick();
    ovr_en[1] = 1'b1;
    ovr_val[1] = 1'b0;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      ovr_val[1] = pat[c];
      tick();
    end
    ovr_en[1] = 1'b0;
    wait_idle(1);
    chk("settle_snap_bit1", int'(snap[1][1]), 1);
    chk("settle_snap_bit2", int'(snap[1][2]), 0);

    // Asynchronous reset mid-scan.
    data[0] = 4'b1111;
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (ss[0] != 2'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_ss2", int'(ss[0]), 2);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", int'({ss[0], snap[0], snap_valid[0], busy[0], overrun[0]}), 0);
    tick();
    rst_n = 1'b1;
    data[0] = 4'b0110;
    exp_q[0].push_back(4'b0110);
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_valid(0, t0);
    wait_idle(0);
    chk("after_reset_snap", int'(snap[0]), 4'b0110);

    // Throughput, DWELL=1, start held high.
    base = ov_cnt[2];
    data[2] = 4'b0011;
    exp_q[2].push_back(4'b0011);
    tick();
    start[2] = 1'b1;
    wait_valid(2, t0);
    data[2] = 4'b1100;
    exp_q[2].push_back(4'b1100);
    wait_valid(2, t1);
    chk("tput_period1", t1 - t0, 6);
    data[2] = 4'b1001;
    exp_q[2].push_back(4'b1001);
    wait_valid(2, t2);
    chk("tput_period2", t2 - t1, 6);
    start[2] = 1'b0;
    wait_idle(2);
    tick();
    tick();
    chk("tput_overruns", ov_cnt[2] - base, 14);

    for (int g = 0; g < 3; g++)
      chk($sformatf("queue_empty_inst%0d", g), exp_q[g].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Select-line sequencer and capture stage that drives the 2-bit select of the 4:1 data mux and collects its single-bit output. On a start request it steps `ss` through channels 0..3, holds each select for a programmable settle time, and samples the mux output at the end of each hold. The four samples are assembled into one 4-bit snapshot word and presented downstream with a valid/ready handshake.

## Interface
- `DWELL`, default 2: number of cycles each select value is held before sampling. Legal range is DWELL ≥ 1; DWELL = 0 is illegal.

- `clk`  input  1  the single clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  scan request; sampled on the rising edge.
- `mux_out`  input  1  output bit of the 4:1 mux.
- `snap_ready`  input  1  downstream accepts the snapshot.
- `ss`  output  2  select driven to the mux; registered.
- `snap`  output  4  snapshot word; bit k is the sample taken with ss = k.
- `snap_valid`  output  1  snapshot available.
- `busy`  output  1  high when state ≠ IDLE.
- `overrun`  output  1  one-cycle pulse for a start that was ignored.

## Operation
- FSM has three states: IDLE, SCAN, OUT.
- **IDLE**
  - `start` = 1 at an edge moves to SCAN.
  - The same edge loads ss ← 0 and dwell counter ← 0.
- **SCAN**
  - The dwell counter increments every edge.
  - When the counter reaches DWELL−1:
    - capture register bit[ss] ← `mux_out`;
    - counter ← 0;
    - ss ← ss+1.
  - On the final channel (ss = 3, counter = DWELL−1):
    - snap ← {mux_out, cap[2:0]};
    - snap_valid ← 1;
    - ss ← 0;
    - move to OUT.
- **OUT**
  - `snap` and `snap_valid` hold stable.
  - An edge with `snap_ready` = 1 clears snap_valid and returns to IDLE.
  - `snap` keeps its last value after the handshake.
- **Ignored start:** `start` = 1 sampled in SCAN or OUT is ignored. It pulses `overrun` high for the following cycle. No restart and no queueing.
- **Sampling point:** only the value of `mux_out` in the last cycle of each dwell is captured. Earlier values in the dwell are don't-care.
- **Counter sizing:** dwell counter width is $clog2(DWELL)+1 bits. It never exceeds DWELL−1.
- **Reset:** rst_n low at any time, including mid-scan or in OUT, immediately forces:
  - state IDLE;
  - ss = 0, snap = 0, snap_valid = 0, busy = 0, overrun = 0;
  - capture register and counter = 0.
  - The partial scan is discarded.

## Timing
- **Reset values:** every output is 0.
- **Latency:** start accepted at edge E0 gives snap_valid = 1 after edge E0 + 4·DWELL.
- **Select sequence:**
  - ss = k during cycles E0 + k·DWELL … E0 + (k+1)·DWELL − 1.
  - ss = 0 in IDLE and OUT.
- **Sample edges:** channel k is sampled at edge E0 + (k+1)·DWELL.
- **Handshake:**
  - Transfer occurs at the first edge where snap_valid = 1 and snap_ready = 1.
  - If snap_ready is already high, valid lasts exactly one cycle.
- **Back-to-back:** minimum period between accepted starts is 4·DWELL + 2 cycles (scan, one OUT cycle, one IDLE cycle).
- **busy timing:** busy rises the cycle after the accepting edge. It falls the cycle after the handshake edge.
- **Combinational paths:** none from inputs to outputs.

## Test plan
- **Basic scan:** DWELL = 2, behavioural mux with data = 4'b1010, snap_ready = 1, start pulsed at E0.
  - ss = 0,0,1,1,2,2,3,3.
  - snap_valid high for 1 cycle after E8, snap = 4'b1010.
  - busy falls after E9.
- **Backpressure:** same scan with snap_ready held low 5 cycles after valid.
  - snap = 4'b1010 and snap_valid hold stable.
  - Release completes the transfer on the next edge, then IDLE.
- **Overrun:** start pulsed at E0 and again at E3 (mid-scan) and in OUT.
  - overrun pulses once per ignored start.
  - The scan completes unchanged with snap from the E0 request.
- **Settle filtering:** DWELL = 3, with mux data bit1 toggling in the first two cycles of its dwell and stable 1 in the third.
  - snap[1] = 1.
- **Reset mid-scan:** rst_n low asynchronously while ss = 2.
  - All outputs read 0 immediately.
  - After release and a new start with data = 4'b0110, snap = 4'b0110.
- **Throughput:** DWELL = 1, start held high, snap_ready = 1.
  - Accepted starts every 6 cycles.
  - overrun pulses for each start sampled in SCAN/OUT.
  - Consecutive snaps track data changes made between scans.
